fft_out_reorder: RTL and testbench
==================================

Name: fft_out_reorder

Overview:
- Output-side companion to the 16-lane FFT datapath: consumes the parallel result blocks (16 complex samples per valid beat, no backpressure) and emits one complex sample per cycle on a valid/ready stream.
- Restores natural frequency order by reading in bit-reversed index order.
- Ping-pong buffer (two banks of N samples): one frame is written while the previous frame is drained.

Parameters:
- WIDTH, 13, signed sample width per re/im component (matches 16-lane FFT output).
- N, 512, FFT frame length in samples; power of 2, multiple of 16, >= 32.
- LANES, 16, samples per input beat; fixed, not to be overridden.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- din_re  input  signed [WIDTH-1:0] x [0:15]  real part, lane l.
- din_im  input  signed [WIDTH-1:0] x [0:15]  imaginary part, lane l.
- din_valid  input  1  beat valid; no ready path upstream.
- dout_re  output  signed [WIDTH-1:0]  serial real output.
- dout_im  output  signed [WIDTH-1:0]  serial imaginary output.
- dout_valid  output  1  output sample valid.
- dout_ready  input  1  downstream accepts sample.
- dout_last  output  1  marks sample n = N-1 of a frame.
- overflow  output  1  sticky; a whole input frame was dropped.
- overflow_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async, rstn=0): dout_valid=0, dout_re=0, dout_im=0, dout_last=0, overflow=0.
  - Both bank-full flags clear; wr_bank=rd_bank=0; beat and read counters 0; read FSM in IDLE.
  - Buffer contents are not reset.
  - Reset mid-frame discards all partial and stored data.
- Write side:
  - Beat counter wb runs 0..N/16-1 and advances on every din_valid beat.
  - Lane l of beat wb is stored at index k = wb*16 + l in bank wr_bank.
  - Accept/drop is decided at wb=0:
    - Bank wr_bank not full: frame accepted.
    - Bank wr_bank full: the whole frame is dropped (beats still counted) and overflow sets.
  - On the final accepted beat: bank full flag sets and wr_bank toggles.
  - A dropped frame sets no flag and does not toggle wr_bank.
  - Gaps in din_valid are allowed anywhere inside a frame.
- Read FSM:
  - IDLE: if bank rd_bank is full, load sample n=0 into the output register, set dout_valid, go to STREAM.
  - STREAM, transfer condition: dout_valid && dout_ready.
    - On transfer: n increments and the register loads index bitrev(n+1, log2 N).
    - While dout_valid && !dout_ready: dout_re, dout_im and dout_last are held stable.
  - dout_last = 1 exactly when n = N-1.
  - On transfer of the last sample, same edge:
    - Bank rd_bank full flag clears and rd_bank toggles.
    - If the other bank is already full, its sample 0 is loaded at that edge (zero-bubble back-to-back); otherwise dout_valid=0 and the FSM returns to IDLE.
- Latency: dout_valid rises 2 clk edges after the edge sampling the final beat of a frame, provided the FSM was in IDLE.
- Simultaneous events: a write-complete on one bank and a read-release on the other bank in the same cycle are both honoured.
  - A bank is never read and written concurrently.
- overflow_clr: clears overflow next edge; a drop decision on the same edge wins (overflow stays 1).
- No arithmetic: samples pass through bit-exact.

Optional Feature:
- Macro: FFT_REORDER_BITREV_EN.
- Defined: read index = bitrev(n, log2 N), as above.
- Undefined: read index = n (natural/arrival order, plain serializer); all handshake, latency and overflow behaviour unchanged.

Test Plan:
- Single frame, N=512: 32 beats with re=k, im=-k, dout_ready=1.
  - Outputs re = 0, 256, 128, 384, 64, ..., 511 with im = -re.
  - dout_last only on the 512th sample.
  - dout_valid rises 2 edges after the last beat.
- Backpressure: same frame with dout_ready toggling 1,0,1,0 and random stalls.
  - Exactly 512 transfers, each value held stable while stalled, no loss or duplication.
- Overflow: three consecutive frames (re = k, k+1000, k+2000) with dout_ready=0.
  - Frames 1-2 stored, frame 3 dropped, overflow=1.
  - Then dout_ready=1: 1024 samples (frame 1 then frame 2) with no bubble at the frame boundary.
  - overflow_clr pulse then clears the flag.
- Gapped input: din_valid 1-in-3 duty over one frame -> output identical to the single-frame case.
- Reset mid-stream: assert rstn=0 at output sample 100.
  - dout_valid=0 immediately (asynchronous).
  - After release, a fresh frame outputs the correct full 512-sample sequence.
- Build without FFT_REORDER_BITREV_EN: single frame -> re = 0, 1, 2, ..., 511.

Source files
------------

// File: rtl/fft_out_reorder.sv
// fft_out_reorder: 16-lane FFT result blocks -> serial stream via ping-pong buffer; bit-reversed read when FFT_REORDER_BITREV_EN is defined
module fft_out_reorder #(
    parameter int WIDTH = 13,
    parameter int N     = 512
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic signed [WIDTH-1:0] din_re [0:15],
    input  logic signed [WIDTH-1:0] din_im [0:15],
    input  logic                    din_valid,
    output logic signed [WIDTH-1:0] dout_re,
    output logic signed [WIDTH-1:0] dout_im,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    dout_last,
    output logic                    overflow,
    input  logic                    overflow_clr
);
    localparam int LANES = 16;
    localparam int LOG2N = $clog2(N);
    localparam int WBW   = LOG2N - 4;
    localparam int ABW   = LOG2N + 1;

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    logic signed [WIDTH-1:0] r_in_re [0:LANES-1];
    logic signed [WIDTH-1:0] r_in_im [0:LANES-1];
    logic                    r_in_valid;
    logic signed [WIDTH-1:0] r_mem_re [0:2*N-1];
    logic signed [WIDTH-1:0] r_mem_im [0:2*N-1];
    logic [WBW-1:0]          r_wb;
    logic                    r_wr_bank;
    logic                    r_drop;
    logic [1:0]              r_full;
    logic                    r_overflow;
    state_t                  r_state;
    logic [LOG2N-1:0]        r_n;
    logic                    r_rd_bank;
    logic                    r_valid;
    logic                    r_last;
    logic signed [WIDTH-1:0] r_re;
    logic signed [WIDTH-1:0] r_im;

    logic                    w_drop_start;
    logic                    w_drop;
    logic                    w_wr_en;
    logic                    w_wr_done;
    logic [1:0]              w_full_nxt;
    state_t                  w_state_nxt;
    logic [LOG2N-1:0]        w_n_nxt;
    logic                    w_load;
    logic                    w_release;
    logic                    w_bank_sel;
    logic [LOG2N-1:0]        w_rd_idx;
    logic [ABW-1:0]          w_raddr;

`ifdef FFT_REORDER_BITREV_EN
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        for (int i = 0; i < LOG2N; i++) bitrev[i] = v[LOG2N-1-i];
    endfunction
    assign w_rd_idx = bitrev(w_n_nxt);
`else
    assign w_rd_idx = w_n_nxt;
`endif

    // Accept/drop is decided on the first beat of a frame and held for the rest of it
    assign w_drop_start = r_in_valid && (r_wb == '0) && r_full[r_wr_bank];
    assign w_drop       = (r_wb == '0) ? r_full[r_wr_bank] : r_drop;
    assign w_wr_en      = r_in_valid && !w_drop;
    assign w_wr_done    = w_wr_en && (&r_wb);
    assign w_raddr      = {w_bank_sel, w_rd_idx};

    assign dout_re    = r_re;
    assign dout_im    = r_im;
    assign dout_valid = r_valid;
    assign dout_last  = r_last;
    assign overflow   = r_overflow;

    // Input beat register and bank storage (contents intentionally not reset)
    always_ff @(posedge clk) begin
        if (din_valid) begin
            for (int l = 0; l < LANES; l++) begin
                r_in_re[l] <= din_re[l];
                r_in_im[l] <= din_im[l];
            end
        end
        if (w_wr_en) begin
            for (int l = 0; l < LANES; l++) begin
                r_mem_re[{r_wr_bank, r_wb, 4'(l)}] <= r_in_re[l];
                r_mem_im[{r_wr_bank, r_wb, 4'(l)}] <= r_in_im[l];
            end
        end
    end

    // Bank full flags: write-complete and read-release always target different banks
    always_comb begin
        w_full_nxt = r_full;
        if (w_release) w_full_nxt[r_rd_bank] = 1'b0;
        if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    end

    // Write-side control: beat counter, bank select, drop tracking, sticky overflow
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_in_valid <= 1'b0;
            r_wb       <= '0;
            r_wr_bank  <= 1'b0;
            r_drop     <= 1'b0;
            r_full     <= 2'b00;
            r_overflow <= 1'b0;
        end else begin
            r_in_valid <= din_valid;
            if (r_in_valid) r_wb <= r_wb + 1'b1;
            if (r_in_valid && r_wb == '0) r_drop <= r_full[r_wr_bank];
            if (w_wr_done) r_wr_bank <= ~r_wr_bank;
            r_full     <= w_full_nxt;
            r_overflow <= w_drop_start ? 1'b1 : overflow_clr ? 1'b0 : r_overflow;
        end
    end

    // Read FSM next state: start a frame from IDLE, advance on transfer, chain banks without a bubble
    always_comb begin
        w_state_nxt = r_state;
        w_n_nxt     = r_n;
        w_load      = 1'b0;
        w_release   = 1'b0;
        w_bank_sel  = r_rd_bank;
        if (r_state == S_IDLE) begin
            if (r_full[r_rd_bank]) begin
                w_load      = 1'b1;
                w_n_nxt     = '0;
                w_state_nxt = S_STREAM;
            end
        end else if (r_valid && dout_ready) begin
            if (&r_n) begin
                w_release  = 1'b1;
                w_n_nxt    = '0;
                w_bank_sel = ~r_rd_bank;
                w_load     = r_full[~r_rd_bank];
                w_state_nxt = r_full[~r_rd_bank] ? S_STREAM : S_IDLE;
            end else begin
                w_load  = 1'b1;
                w_n_nxt = r_n + 1'b1;
            end
        end
    end

    // Read FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Output register: loads a new sample on start/transfer, holds while stalled
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_n       <= '0;
            r_rd_bank <= 1'b0;
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_re      <= '0;
            r_im      <= '0;
        end else begin
            r_n     <= w_n_nxt;
            r_valid <= (w_state_nxt == S_STREAM);
            if (w_release) r_rd_bank <= ~r_rd_bank;
            if (w_load) begin
                r_re   <= r_mem_re[w_raddr];
                r_im   <= r_mem_im[w_raddr];
                r_last <= &w_n_nxt;
            end else if (w_state_nxt == S_IDLE) begin
                r_last <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fft_out_reorder.sv
// tb_fft_out_reorder: directed bench for fft_out_reorder (ordering, backpressure, overflow, gaps, async reset)
module tb_fft_out_reorder;
    localparam int N = 512;
    localparam int W = 13;

    logic                clk = 1'b0;
    logic                rstn;
    logic signed [W-1:0] din_re [0:15];
    logic signed [W-1:0] din_im [0:15];
    logic                din_valid;
    logic signed [W-1:0] dout_re;
    logic signed [W-1:0] dout_im;
    logic                dout_valid;
    logic                dout_ready;
    logic                dout_last;
    logic                overflow;
    logic                overflow_clr;

    int n_tests = 0;
    int n_fail  = 0;
    int span;

    fft_out_reorder #(.WIDTH(W), .N(N)) dut (
        .clk(clk), .rstn(rstn), .din_re(din_re), .din_im(din_im), .din_valid(din_valid),
        .dout_re(dout_re), .dout_im(dout_im), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_last(dout_last), .overflow(overflow), .overflow_clr(overflow_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int map_idx(input int j);
`ifdef FFT_REORDER_BITREV_EN
        int r = 0;
        for (int b = 0; b < 9; b++) if (j & (1 << b)) r |= 1 << (8 - b);
        return r;
`else
        return j;
`endif
    endfunction

    task automatic send_frame(input int base, input int gap);
        for (int b = 0; b < N / 16; b++) begin
            @(negedge clk);
            din_valid = 1'b1;
            for (int l = 0; l < 16; l++) begin
                din_re[l] = W'(b * 16 + l + base);
                din_im[l] = W'(-(b * 16 + l + base));
            end
            repeat (gap) begin
                @(negedge clk);
                din_valid = 1'b0;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic recv(input int nsamp, input int base, input int mode, output int sp);
        int i = 0;
        int cyc = 0;
        int first = -1;
        int last_t = 0;
        int e, j, hre, him, hl;
        bit stalled = 0;
        bit rdy;
        while (i < nsamp && cyc < nsamp * 4 + 200) begin
            @(negedge clk);
            cyc++;
            if (stalled) begin
                check("hold_valid", int'(dout_valid), 1);
                check("hold_re", int'(dout_re), hre);
                check("hold_im", int'(dout_im), him);
                check("hold_last", int'(dout_last), hl);
            end
            rdy = (mode == 0) || (mode == 1 && cyc % 2 == 0) || (mode == 2 && $urandom_range(0, 2) != 0);
            dout_ready = rdy;
            stalled = dout_valid && !rdy;
            hre = int'(dout_re);
            him = int'(dout_im);
            hl  = int'(dout_last);
            if (dout_valid && rdy) begin
                j = i % N;
                e = map_idx(j) + base + (i / N) * 1000;
                check($sformatf("re[%0d]", i), int'(dout_re), e);
                check($sformatf("im[%0d]", i), int'(dout_im), -e);
                check($sformatf("last[%0d]", i), int'(dout_last), int'(j == N - 1));
                if (first < 0) first = cyc;
                last_t = cyc;
                i++;
            end
        end
        @(negedge clk);
        dout_ready = 1'b0;
        check("recv_count", i, nsamp);
        sp = last_t - first;
    endtask

    initial begin
        rstn = 1'b0;
        din_valid = 1'b0;
        dout_ready = 1'b0;
        overflow_clr = 1'b0;
        for (int l = 0; l < 16; l++) begin
            din_re[l] = '0;
            din_im[l] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_valid", int'(dout_valid), 0);
        check("rst_re", int'(dout_re), 0);
        check("rst_im", int'(dout_im), 0);
        check("rst_last", int'(dout_last), 0);
        check("rst_ovf", int'(overflow), 0);
        rstn = 1'b1;

        // single frame with latency
        send_frame(0, 0);
        check("lat0", int'(dout_valid), 0);
        @(negedge clk);
        check("lat1", int'(dout_valid), 0);
        @(negedge clk);
        check("lat2", int'(dout_valid), 1);
        recv(N, 0, 0, span);
        check("single_span", span, N - 1);
        repeat (3) @(negedge clk);
        check("single_idle", int'(dout_valid), 0);

        // backpressure: alternating and random stalls
        send_frame(0, 0);
        recv(N, 0, 1, span);
        send_frame(0, 0);
        recv(N, 0, 2, span);
        repeat (3) @(negedge clk);
        check("bp_idle", int'(dout_valid), 0);

        // overflow: two frames stored, third dropped, back-to-back drain
        send_frame(0, 0);
        send_frame(1000, 0);
        check("ovf_before", int'(overflow), 0);
        send_frame(2000, 0);
        @(negedge clk);
        check("ovf_set", int'(overflow), 1);
        recv(2 * N, 0, 0, span);
        check("ovf_nobubble", span, 2 * N - 1);
        repeat (5) @(negedge clk);
        check("ovf_dropped", int'(dout_valid), 0);
        check("ovf_sticky", int'(overflow), 1);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        check("ovf_clr", int'(overflow), 0);

        // gapped input, 1-in-3 duty
        send_frame(0, 2);
        recv(N, 0, 0, span);
        repeat (3) @(negedge clk);
        check("gap_idle", int'(dout_valid), 0);

        // asynchronous reset mid-stream
        send_frame(0, 0);
        recv(100, 0, 0, span);
        check("pre_rst_valid", int'(dout_valid), 1);
        #1 rstn = 1'b0;
        #1;
        check("async_valid", int'(dout_valid), 0);
        check("async_re", int'(dout_re), 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_idle", int'(dout_valid), 0);
        send_frame(0, 0);
        recv(N, 0, 0, span);
        repeat (3) @(negedge clk);
        check("post_rst_end", int'(dout_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
